seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Multiplexed, parametrised seven-segment display driver: latches a NUM_DIGITS-nibble hex value on a load strobe and time-multiplexes it onto one shared segment bus with one enable line per digit. It replaces per-digit combinational decoders on the board-level display path: one segment bus plus NUM_DIGITS enables instead of 7×NUM_DIGITS pins. It adds a refresh prescaler, digit scan, per-digit blanking and an anti-ghosting dead cycle.

## Interface
- NUM_DIGITS, 4: digits scanned, legal 1..8
- CLK_DIV, 50000: clock cycles per digit slot, legal ≥ 2
- ACTIVE_LOW, 1: 1 means segments and enables are driven 0 = on; 0 means 1 = on
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
- load  in  1  captures value into the shadow register
- blank_mask  in  NUM_DIGITS  bit i = 1 forces digit i dark; sampled live, not latched
- seg  out  7  segment bus, bit order g f e d c b a (bit 6 = g)
- an  out  NUM_DIGITS  digit enables, one-hot or all-off

## Operation
- Shadow register: at the rising edge where load = 1 and rst = 0, shadow ← value. The display uses only the shadow register, never value directly.
- Prescaler cnt counts 0..CLK_DIV-1 and wraps to 0. Digit index idx advances when cnt wraps, counting 0..NUM_DIGITS-1 and wrapping to 0.
- Each digit slot lasts CLK_DIV cycles:
  - First cycle of the slot is the dead cycle: an all off, seg all off.
  - Remaining CLK_DIV-1 cycles: an[idx] on, seg = decode(shadow nibble idx).
- Decode table, active-low form, gfedcba: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 B:03 C:46 D:21 E:06 F:0E (hex). With ACTIVE_LOW = 0, seg and an are the bitwise inverse.
- A dark digit keeps its full slot duration but holds an all off and seg all off. A digit is dark if blank_mask[idx] = 1, or if it is blanked by the Configuration feature.
- Output state by cycle:
  - an is never multi-hot.
  - seg is never non-off while an is all off.

## Timing
- Reset values: cnt = 0, idx = 0, shadow = 0, seg all off, an all off. These values match the dead cycle of the slot for digit 0.
- Outputs are registered. Cycle k counts edges after rst is deasserted, starting at k = 0.
  - Slot number = k / CLK_DIV; digit shown = slot mod NUM_DIGITS.
  - Cycle k is a dead cycle when k mod CLK_DIV = 0.
- Load latency: a load at edge t affects seg from edge t+1 onward, if digit idx is lit at t+1.
- Load at the same edge as a slot boundary: the new slot uses the new shadow value.
- A change on blank_mask is visible on outputs 1 cycle later.
- rst asserted mid-slot: at the next edge all state returns to reset values and the scan restarts at digit 0. rst overrides load at the same edge.

## Configuration
- SEVEN_SEG_LZB_EN defined: leading-zero blanking is compiled in.
  - Digit i > 0 is dark when shadow nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is always eligible to light, so shadow = 0 shows a single "0".
  - Blanking is computed from shadow only.
- Macro undefined: no leading-zero blanking. Every digit not masked by blank_mask is lit in its slot.

## Structure
- Package seven_seg_pkg holds:
  - SEG_OFF_AL constant, 7'h7F;
  - the 16-entry active-low segment pattern constant array;
  - a typedef for the 7-bit segment vector.
- Sub-module seg_decode: combinational 4-bit nibble to 7-bit active-low pattern, one instance fed by the selected shadow nibble. Polarity inversion happens in the top block.
- Counter widths: cnt is $clog2(CLK_DIV) bits; idx is max(1, $clog2(NUM_DIGITS)) bits.

## Test plan
All cases use NUM_DIGITS = 4, CLK_DIV = 4, ACTIVE_LOW = 1.
- Reset: pulse rst, load value = 16'h1234 → k = 0: an = 4'hF, seg = 7'h7F. k = 1..3: an = 4'b1110, seg = 7'h19 ("4"). k = 4: dead. k = 5..7: an = 4'b1101, seg = 7'h30 ("3").
- Scan wrap: run 17 cycles after reset → digit 3 lit during k = 13..15; k = 16 is dead; digit 0 lit at k = 17.
- Load timing: shadow = 16'h0000, then load 16'hFFFF at k = 2 → seg = 7'h40 at k = 2 and 7'h0E at k = 3. Load at k = 4 with 16'hAAAA → k = 5 shows 7'h08.
- Blanking: blank_mask = 4'b0100 → during digit 2's slot, an = 4'hF and seg = 7'h7F for all 4 cycles; other digits unaffected.
- Leading-zero (SEVEN_SEG_LZB_EN defined): shadow = 16'h0050 → digits 3 and 2 dark, digits 1 and 0 show "5" and "0". shadow = 0 → only digit 0 shows 7'h40. Without the macro → all four digits show "0".
- Mid-slot reset at k = 6 → at k = 7, an = 4'hF and shadow = 0. Digit 0 lit at k = 8..10, showing 7'h40.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment vectors are ordered g f e d c b a (bit 6 = g) and stored active-low.
package seven_seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF_AL = 7'h7F;

   // Active-low gfedcba patterns for hex digits 0..F.
   localparam seg_t SEG_TABLE_AL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle: hex value, load strobe, live blank mask in; segment bus and enables out.
interface seven_seg_scan_if
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4
) ();

   logic [4*NUM_DIGITS-1:0] value;
   logic                    load;
   logic [NUM_DIGITS-1:0]   blank_mask;
   seg_t                    seg;
   logic [NUM_DIGITS-1:0]   an;

   modport master (output value, load, blank_mask, input seg, an);
   modport slave  (input value, load, blank_mask, output seg, an);

endinterface

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg_al
);

   assign seg_al = SEG_TABLE_AL[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment scanner: shadow register, refresh prescaler, digit scan,
// per-digit blanking and a dead cycle at the start of every slot against ghosting.
// Optional: define SEVEN_SEG_LZB_EN to compile in leading-zero blanking.
// Outputs are registered and computed from next-state, so they always describe cnt_q/idx_q.
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned CLK_DIV    = 50000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input logic              clk,
   input logic              rst,
   seven_seg_scan_if.slave  bus
);

   localparam int unsigned CntW = $clog2(CLK_DIV);
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam seg_t                  SegOff = ACTIVE_LOW ? SEG_OFF_AL : ~SEG_OFF_AL;
   localparam logic [NUM_DIGITS-1:0] AnOff  = ACTIVE_LOW ? '1 : '0;

   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   seg_t                    seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic [3:0]              nibble;
   seg_t                    dec_al;
   logic                    dark;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   an_sel_al;
   logic [NUM_DIGITS-1:0]   lz_dark;

   // Shadow capture and prescaler / digit-index advance.
   always_comb begin
      shadow_d = bus.load ? bus.value : shadow_q;
      cnt_d    = cnt_q + CntW'(1);
      idx_d    = idx_q;
      if (cnt_q == CntW'(CLK_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
      end
   end

`ifdef SEVEN_SEG_LZB_EN
   // Digit i > 0 is dark when it and every more-significant nibble are zero; digit 0 never is.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      lz_dark  = '0;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         zero_run   = zero_run & (shadow_d[4*i +: 4] == 4'h0);
         lz_dark[i] = zero_run;
      end
   end
`else
   assign lz_dark = '0;
`endif

   // Select the nibble, blanking state and active-low enable for the upcoming digit.
   always_comb begin
      nibble    = 4'h0;
      dark      = 1'b0;
      an_sel_al = '1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (idx_d == IdxW'(i)) begin
            nibble       = shadow_d[4*i +: 4];
            dark         = bus.blank_mask[i] | lz_dark[i];
            an_sel_al[i] = 1'b0;
         end
      end
   end

   seg_decode u_seg_decode (
      .nibble (nibble),
      .seg_al (dec_al)
   );

   // Dead first cycle of each slot and dark digits drive everything off; then apply polarity.
   always_comb begin
      lit   = (cnt_d != '0) && !dark;
      seg_d = lit ? dec_al : SEG_OFF_AL;
      an_d  = lit ? an_sel_al : '1;
      if (!ACTIVE_LOW) begin
         seg_d = ~seg_d;
         an_d  = ~an_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         seg_q    <= SegOff;
         an_q     <= AnOff;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Table-driven bench for seven_seg_scan with NUM_DIGITS = 4, CLK_DIV = 4, ACTIVE_LOW = 1.
// Each record: inputs driven before an edge, expected outputs sampled 1 time unit after it.
module tb_seven_seg_scan;

   localparam int unsigned ND = 4;
`ifdef SEVEN_SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   seven_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

   seven_seg_scan #(
      .NUM_DIGITS (ND),
      .CLK_DIV    (4),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        load;
      logic [15:0] value;
      logic [3:0]  mask;
      logic [3:0]  an;
      logic [6:0]  seg;
      string       tag;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   task automatic addn(input int n, input logic r, input logic l, input logic [15:0] v,
                       input logic [3:0] m, input logic [3:0] an, input logic [6:0] s,
                       input string tag);
      vec_t e;
      e.rst = r; e.load = l; e.value = v; e.mask = m; e.an = an; e.seg = s; e.tag = tag;
      for (int i = 0; i < n; i++) vecs.push_back(e);
   endtask

   initial begin
      bus.load       = 1'b0;
      bus.value      = '0;
      bus.blank_mask = '0;

      // Reset and full scan wrap with 16'h1234.
      addn(1, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "rst_k0");
      addn(3, 0, 1, 16'h1234, 4'h0, 4'hE, 7'h19, "d0_4");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "dead_k4");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h30, "d1_3");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "dead_k8");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hB, 7'h24, "d2_2");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "dead_k12");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'h7, 7'h79, "d3_1");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "dead_k16");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h19, "wrap_k17");

      // Load timing: shadow 0, load FFFF in cycle 2, AAAA at the slot boundary.
      addn(1, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "ld_rst");
      addn(2, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h40, "ld_old");
      addn(1, 0, 1, 16'hFFFF, 4'h0, 4'hE, 7'h0E, "ld_new");
      addn(1, 0, 1, 16'hAAAA, 4'h0, 4'hF, 7'h7F, "ld_bnd_dead");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h08, "ld_bnd_a");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "ld_dead_k8");

      // Blanking: digit 2 masked, then a live mask change onto digit 3 mid-slot.
      addn(1, 1, 0, 16'h0000, 4'h4, 4'hF, 7'h7F, "bl_rst");
      addn(3, 0, 1, 16'h1234, 4'h4, 4'hE, 7'h19, "bl_d0");
      addn(1, 0, 0, 16'h0000, 4'h4, 4'hF, 7'h7F, "bl_dead4");
      addn(3, 0, 0, 16'h0000, 4'h4, 4'hD, 7'h30, "bl_d1");
      addn(4, 0, 0, 16'h0000, 4'h4, 4'hF, 7'h7F, "bl_d2_dark");
      addn(1, 0, 0, 16'h0000, 4'h4, 4'hF, 7'h7F, "bl_dead12");
      addn(1, 0, 0, 16'h0000, 4'h4, 4'h7, 7'h79, "bl_d3_lit");
      addn(2, 0, 0, 16'h0000, 4'h8, 4'hF, 7'h7F, "bl_d3_live");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "bl_dead16");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h19, "bl_d0_again");

      // Leading-zero blanking with 0050, then 0000.
      addn(1, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_rst");
      addn(3, 0, 1, 16'h0050, 4'h0, 4'hE, 7'h40, "lz_d0");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_dead4");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h12, "lz_d1_5");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_dead8");
      addn(3, 0, 0, 16'h0000, 4'h0, LZB ? 4'hF : 4'hB, LZB ? 7'h7F : 7'h40, "lz_d2");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_dead12");
      addn(3, 0, 0, 16'h0000, 4'h0, LZB ? 4'hF : 4'h7, LZB ? 7'h7F : 7'h40, "lz_d3");
      addn(1, 0, 1, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_zero_dead");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h40, "lz_zero_d0");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "lz_zero_dead20");
      addn(3, 0, 0, 16'h0000, 4'h0, LZB ? 4'hF : 4'hD, LZB ? 7'h7F : 7'h40, "lz_zero_d1");

      // Mid-slot reset in cycle 6, overriding a simultaneous load.
      addn(1, 1, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "mr_rst");
      addn(3, 0, 1, 16'h1234, 4'h0, 4'hE, 7'h19, "mr_d0");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "mr_dead4");
      addn(2, 0, 0, 16'h0000, 4'h0, 4'hD, 7'h30, "mr_d1");
      addn(1, 1, 1, 16'hFFFF, 4'h0, 4'hF, 7'h7F, "mr_k7_reset");
      addn(3, 0, 0, 16'h0000, 4'h0, 4'hE, 7'h40, "mr_d0_zero");
      addn(1, 0, 0, 16'h0000, 4'h0, 4'hF, 7'h7F, "mr_dead11");

      foreach (vecs[n]) begin
         rst            = vecs[n].rst;
         bus.load       = vecs[n].load;
         bus.value      = vecs[n].value;
         bus.blank_mask = vecs[n].mask;
         @(posedge clk);
         #1;
         total++;
         if (bus.an !== vecs[n].an || bus.seg !== vecs[n].seg) begin
            bad++;
            $display("FAIL %s (vec %0d): an=%h seg=%h, required an=%h seg=%h", vecs[n].tag, n,
                     bus.an, bus.seg, vecs[n].an, vecs[n].seg);
         end
         total++;
         if ($countones(~bus.an) > 1 || (bus.an == 4'hF && bus.seg != 7'h7F)) begin
            bad++;
            $display("FAIL invariant (vec %0d): an=%h seg=%h, required one-hot-or-off, dark seg",
                     n, bus.an, bus.seg);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
